fft3_frame_feeder: RTL and testbench

- Input-side counterpart of the radix-3 SDF FFT core: collects one frame of N = 3^Stages complex samples from a bursty valid/ready source.
- Replays the frame to the FFT core as a single contiguous burst, with di_en held high for exactly N cycles and a stable Stages code for the whole burst.
- Sits directly in front of the FFT3 instance in the PUSCH chain.

---
 rtl/fft3_pkg.sv | 26 ++
 rtl/fft3_frame_ram.sv | 35 +++
 rtl/fft3_frame_feeder.sv | 127 ++++++++++++
 tb/tb_fft3_frame_feeder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft3_pkg.sv
// Shared definitions for the radix-3 FFT front end: frame-size decode and
// the feeder state encoding.
package fft3_pkg;

    localparam int N_MAX  = 243;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } feeder_state_t;

    // Frame length for a Stages code; 0 marks a code the FFT cannot run.
    function automatic logic [ADDR_W-1:0] stages_to_n(input logic [2:0] stages);
        case (stages)
            3'd1:    stages_to_n = 8'd3;
            3'd2:    stages_to_n = 8'd9;
            3'd3:    stages_to_n = 8'd27;
            3'd4:    stages_to_n = 8'd81;
            3'd5:    stages_to_n = 8'd243;
            default: stages_to_n = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/fft3_frame_ram.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read.
module fft3_frame_ram
    import fft3_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int DEPTH  = N_MAX
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: no reset on the array or read register, so the storage maps onto
    // block RAM; unwritten contents are never driven out (do_en masks them).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so a read and write in the same cycle see the
        // pre-edge array contents, exactly like the physical RAM.
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft3_frame_feeder.sv
// Collects one N = 3^Stages frame from a bursty valid/ready source and
// replays it to the FFT3 core as a single contiguous do_en burst.
module fft3_frame_feeder
    import fft3_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int N_MAX = fft3_pkg::N_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [2:0]       stages_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             in_ready,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic [2:0]       stages_out,
    output logic             frame_done
);

    feeder_state_t      state_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [ADDR_W-1:0]  last_idx_q;
    logic [2:0]         stages_q;
    logic               ready_en_q;
    logic               do_en_q;
    logic               frame_done_q;

    logic               code_ok;
    logic               accept;
    logic               wr_last;
    logic               rd_last;
    logic [2*WIDTH-1:0] rd_data;

    // ready_en_q keeps in_ready low for the cycle in which the last do_en is
    // on the bus, guaranteeing an idle cycle between bursts.
    assign code_ok  = (stages_to_n(stages_in) != '0);
    assign in_ready = ready_en_q && ((state_q == FILL) || ((state_q == IDLE) && code_ok));
    assign accept   = in_valid && in_ready && !clr;
    assign wr_last  = (wr_addr_q == last_idx_q);
    assign rd_last  = (rd_addr_q == last_idx_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            last_idx_q   <= '0;
            stages_q     <= '0;
            ready_en_q   <= 1'b0;
            do_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (clr) begin
            // Abort wins over any accept; stages_q deliberately keeps its value.
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            ready_en_q   <= 1'b1;
            do_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            do_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_en_q <= 1'b1;
                    if (accept) begin
                        stages_q   <= stages_in;
                        last_idx_q <= stages_to_n(stages_in) - ADDR_W'(1);
                        wr_addr_q  <= ADDR_W'(1);
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (wr_last) begin
                            wr_addr_q  <= '0;
                            rd_addr_q  <= '0;
                            ready_en_q <= 1'b0;
                            state_q    <= DRAIN;
                        end else begin
                            wr_addr_q <= wr_addr_q + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // do_en lags the read address by the RAM's one-cycle read.
                    do_en_q <= 1'b1;
                    if (rd_last) begin
                        frame_done_q <= 1'b1;
                        rd_addr_q    <= '0;
                        state_q      <= IDLE;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fft3_frame_ram #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (N_MAX)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_addr_q),
        .wr_data ({in_re, in_im}),
        .rd_en   (state_q == DRAIN),
        .rd_addr (rd_addr_q),
        .rd_data (rd_data)
    );

    assign do_en      = do_en_q;
    assign do_re      = do_en_q ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign do_im      = do_en_q ? rd_data[WIDTH-1:0] : '0;
    assign stages_out = stages_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft3_frame_feeder.sv
// Randomized scenario bench for fft3_frame_feeder against a frame-level model:
// a burst must replay the accepted samples in order, 2 cycles after the last accept.
module tb_fft3_frame_feeder;

    localparam int W  = 18;
    localparam int DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [2:0]    stages_in;
    logic          in_valid;
    logic [W-1:0]  in_re;
    logic [W-1:0]  in_im;
    logic          in_ready;
    logic          do_en;
    logic [W-1:0]  do_re;
    logic [W-1:0]  do_im;
    logic [2:0]    stages_out;
    logic          frame_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] cap_data[$];
    int            fill_got, fill_stage_changes;
    logic [2:0]    fill_stage0;
    int            cap_first, cap_last, cap_count, cap_done_cnt, cap_done_idx;
    int            cap_zero_viol, cap_stage_changes, cap_ready_rise;
    logic [2:0]    cap_stage0;

    fft3_frame_feeder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .stages_in  (stages_in),
        .in_valid   (in_valid),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_ready   (in_ready),
        .do_en      (do_en),
        .do_re      (do_re),
        .do_im      (do_im),
        .stages_out (stages_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Frame length from the Stages code: N = 3^Stages for codes 1..5.
    function automatic int model_n(input int st);
        return (st >= 1 && st <= 5) ? 3 ** st : 0;
    endfunction

    task automatic next_sample(input int base, input int idx,
                               output logic [W-1:0] re, output logic [W-1:0] im);
        if (base < 0) begin
            re = W'($urandom);
            im = W'($urandom);
        end else begin
            re = W'(base + idx);
            im = W'(-(base + idx));
        end
    endtask

    // Offers samples until n_acc are accepted; mode 0 continuous, 1 toggling, 2 random gaps.
    task automatic fill_frame(input logic [2:0] st, input int n_acc, input int mode,
                              input logic [2:0] st_after, input int base);
        int budget, k, seen;
        logic acc;
        logic [W-1:0] re, im;
        budget = 8 * n_acc + 64;
        k = 0;
        seen = 0;
        fill_got = 0;
        fill_stage_changes = 0;
        fill_stage0 = '0;
        stages_in = st;
        next_sample(base, 0, re, im);
        while (fill_got < n_acc && budget > 0) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (k % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            in_re = re;
            in_im = im;
            @(negedge clk);
            if (fill_got >= 1) begin
                if (seen == 0) begin
                    fill_stage0 = stages_out;
                    seen = 1;
                end else if (stages_out !== fill_stage0) begin
                    fill_stage_changes++;
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent_q.push_back({re, im});
                fill_got++;
                if (fill_got == 1) stages_in = st_after;
                next_sample(base, fill_got, re, im);
            end
            k++;
            budget--;
        end
        in_valid = 1'b0;
    endtask

    // Records outputs for n_cyc cycles starting the cycle after the last accept edge.
    task automatic capture(input int n_cyc, input int clr_at);
        cap_data.delete();
        cap_first = -1; cap_last = -1; cap_count = 0; cap_done_cnt = 0; cap_done_idx = -1;
        cap_zero_viol = 0; cap_stage_changes = 0; cap_ready_rise = -1; cap_stage0 = '0;
        for (int i = 0; i < n_cyc; i++) begin
            clr = (i == clr_at);
            @(negedge clk);
            if (do_en) begin
                if (cap_first < 0) cap_first = i;
                cap_last = i;
                cap_count++;
                cap_data.push_back({do_re, do_im});
            end else if (do_re !== '0 || do_im !== '0) begin
                cap_zero_viol++;
            end
            if (frame_done) begin
                cap_done_cnt++;
                cap_done_idx = i;
            end
            if (i == 0) cap_stage0 = stages_out;
            else if (stages_out !== cap_stage0) cap_stage_changes++;
            if (in_ready && cap_ready_rise < 0) cap_ready_rise = i;
            @(posedge clk); #1;
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        stages_in = 3'd1;
        #12;
        vectors++; if (in_ready !== 1'b0 || do_en !== 1'b0) begin miscompares++; $display("FAIL reset hs: in_ready %b do_en %b want 0 0", in_ready, do_en); end
        vectors++; if (do_re !== '0 || do_im !== '0) begin miscompares++; $display("FAIL reset data: %h %h want 0 0", do_re, do_im); end
        vectors++; if (stages_out !== 3'd0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL reset misc: stages %0d done %b want 0 0", stages_out, frame_done); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset release: in_ready %b want 1", in_ready); end
    endtask

    task automatic test_min_frame();
        sent_q.delete();
        fill_frame(3'd1, 3, 0, 3'd1, 1);
        capture(7, -1);
        vectors++; if (fill_got !== 3) begin miscompares++; $display("FAIL min accepts: got %0d want 3", fill_got); end
        vectors++; if (cap_first !== 1 || cap_last !== 3 || cap_count !== 3) begin miscompares++; $display("FAIL min window: first %0d last %0d count %0d want 1 3 3", cap_first, cap_last, cap_count); end
        vectors++; if (cap_done_cnt !== 1 || cap_done_idx !== 3) begin miscompares++; $display("FAIL min done: cnt %0d idx %0d want 1 3", cap_done_cnt, cap_done_idx); end
        vectors++; if (fill_stage0 !== 3'd1 || cap_stage0 !== 3'd1 || cap_stage_changes !== 0) begin miscompares++; $display("FAIL min stages: %0d %0d chg %0d want 1 1 0", fill_stage0, cap_stage0, cap_stage_changes); end
        vectors++; if (cap_ready_rise !== 4 || cap_zero_viol !== 0) begin miscompares++; $display("FAIL min ready/zero: rise %0d zero %0d want 4 0", cap_ready_rise, cap_zero_viol); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL min data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_max_frame_gaps();
        sent_q.delete();
        fill_frame(3'd5, 243, 1, 3'd5, 0);
        capture(247, -1);
        vectors++; if (fill_got !== 243) begin miscompares++; $display("FAIL max accepts: got %0d want 243", fill_got); end
        vectors++; if (cap_first !== 1 || cap_last !== 243 || cap_count !== 243) begin miscompares++; $display("FAIL max window: first %0d last %0d count %0d want 1 243 243", cap_first, cap_last, cap_count); end
        vectors++; if (cap_done_cnt !== 1 || cap_done_idx !== 243) begin miscompares++; $display("FAIL max done: cnt %0d idx %0d want 1 243", cap_done_cnt, cap_done_idx); end
        vectors++; if (cap_stage0 !== 3'd5 || cap_stage_changes !== 0 || cap_ready_rise !== 244) begin miscompares++; $display("FAIL max stages/ready: %0d chg %0d rise %0d want 5 0 244", cap_stage0, cap_stage_changes, cap_ready_rise); end
        for (int k = 0; k < 243; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL max data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_stages_hold();
        sent_q.delete();
        fill_frame(3'd2, 9, 2, 3'd4, -1);
        capture(13, -1);
        vectors++; if (fill_stage0 !== 3'd2 || fill_stage_changes !== 0) begin miscompares++; $display("FAIL hold fill stages: %0d chg %0d want 2 0", fill_stage0, fill_stage_changes); end
        vectors++; if (cap_stage0 !== 3'd2 || cap_stage_changes !== 0 || cap_count !== 9) begin miscompares++; $display("FAIL hold drain: stages %0d chg %0d count %0d want 2 0 9", cap_stage0, cap_stage_changes, cap_count); end
        for (int k = 0; k < 9; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL hold data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
        sent_q.delete();
        fill_frame(3'd4, 81, 2, 3'd4, -1);
        capture(85, -1);
        vectors++; if (cap_stage0 !== 3'd4 || cap_first !== 1 || cap_last !== 81 || cap_count !== 81) begin miscompares++; $display("FAIL hold next: stages %0d first %0d last %0d count %0d want 4 1 81 81", cap_stage0, cap_first, cap_last, cap_count); end
        for (int k = 0; k < 81; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL hold next data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_invalid_codes();
        logic [2:0] codes [3];
        codes[0] = 3'd0; codes[1] = 3'd6; codes[2] = 3'd7;
        for (int c = 0; c < 3; c++) begin
            stages_in = codes[c];
            in_valid  = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                vectors++; if (in_ready !== 1'b0 || do_en !== 1'b0) begin miscompares++; $display("FAIL invalid code %0d: in_ready %b do_en %b want 0 0", codes[c], in_ready, do_en); end
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        sent_q.delete();
        fill_frame(3'd3, 27, 2, 3'd3, -1);
        capture(31, -1);
        vectors++; if (cap_stage0 !== 3'd3 || cap_first !== 1 || cap_count !== 27 || cap_done_idx !== 27) begin miscompares++; $display("FAIL invalid recover: stages %0d first %0d count %0d done %0d want 3 1 27 27", cap_stage0, cap_first, cap_count, cap_done_idx); end
        for (int k = 0; k < 27; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL invalid data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_clr();
        sent_q.delete();
        fill_frame(3'd2, 5, 2, 3'd2, -1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        vectors++; if (do_en !== 1'b0) begin miscompares++; $display("FAIL clr fill: do_en %b want 0", do_en); end
        @(posedge clk); #1;
        sent_q.delete();
        fill_frame(3'd2, 9, 0, 3'd2, 100);
        capture(13, -1);
        vectors++; if (cap_first !== 1 || cap_last !== 9 || cap_count !== 9 || cap_done_idx !== 9) begin miscompares++; $display("FAIL clr fresh window: first %0d last %0d count %0d done %0d want 1 9 9 9", cap_first, cap_last, cap_count, cap_done_idx); end
        for (int k = 0; k < 9; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL clr fresh data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
        sent_q.delete();
        fill_frame(3'd2, 9, 2, 3'd2, -1);
        capture(13, 4);
        vectors++; if (cap_first !== 1 || cap_last !== 4 || cap_count !== 4) begin miscompares++; $display("FAIL clr burst window: first %0d last %0d count %0d want 1 4 4", cap_first, cap_last, cap_count); end
        vectors++; if (cap_done_cnt !== 0 || cap_zero_viol !== 0) begin miscompares++; $display("FAIL clr burst done/zero: %0d %0d want 0 0", cap_done_cnt, cap_zero_viol); end
        vectors++; if (cap_stage0 !== 3'd2 || cap_stage_changes !== 0 || cap_ready_rise !== 5) begin miscompares++; $display("FAIL clr burst stages/ready: %0d chg %0d rise %0d want 2 0 5", cap_stage0, cap_stage_changes, cap_ready_rise); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL clr burst data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_async_rst();
        sent_q.delete();
        fill_frame(3'd2, 9, 0, 3'd2, -1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (do_en !== 1'b1) begin miscompares++; $display("FAIL rst pre: do_en %b want 1", do_en); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if ({in_ready, do_en, frame_done} !== 3'b000 || stages_out !== 3'd0) begin miscompares++; $display("FAIL rst async ctl: rdy %b en %b done %b stages %0d want 0", in_ready, do_en, frame_done, stages_out); end
        vectors++; if (do_re !== '0 || do_im !== '0) begin miscompares++; $display("FAIL rst async data: %h %h want 0 0", do_re, do_im); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (in_ready !== 1'b1 || do_en !== 1'b0) begin miscompares++; $display("FAIL rst release: in_ready %b do_en %b want 1 0", in_ready, do_en); end
        sent_q.delete();
        fill_frame(3'd1, 3, 2, 3'd1, -1);
        capture(7, -1);
        vectors++; if (cap_first !== 1 || cap_count !== 3 || cap_done_idx !== 3) begin miscompares++; $display("FAIL rst recover: first %0d count %0d done %0d want 1 3 3", cap_first, cap_count, cap_done_idx); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL rst data[%0d]: got %h want %h", k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
        end
    endtask

    task automatic test_random_frames();
        int st, n, mode, exp_rise;
        logic [2:0] st_after;
        for (int f = 0; f < 6; f++) begin
            st       = $urandom_range(1, 4);
            mode     = $urandom_range(0, 2);
            st_after = 3'($urandom_range(0, 7));
            n        = model_n(st);
            exp_rise = (model_n(int'(st_after)) != 0) ? n + 1 : -1;
            sent_q.delete();
            fill_frame(3'(st), n, mode, st_after, -1);
            capture(n + 4, -1);
            vectors++; if (cap_first !== 1 || cap_last !== n || cap_count !== n) begin miscompares++; $display("FAIL rand%0d window: first %0d last %0d count %0d want 1 %0d %0d", f, cap_first, cap_last, cap_count, n, n); end
            vectors++; if (cap_done_cnt !== 1 || cap_done_idx !== n || cap_stage0 !== 3'(st)) begin miscompares++; $display("FAIL rand%0d done/stage: cnt %0d idx %0d stage %0d want 1 %0d %0d", f, cap_done_cnt, cap_done_idx, cap_stage0, n, st); end
            vectors++; if (cap_ready_rise !== exp_rise) begin miscompares++; $display("FAIL rand%0d ready rise: %0d want %0d", f, cap_ready_rise, exp_rise); end
            for (int k = 0; k < n; k++) begin
                vectors++; if (k >= cap_data.size() || cap_data[k] !== sent_q[k]) begin miscompares++; $display("FAIL rand%0d data[%0d]: got %h want %h", f, k, (k < cap_data.size()) ? cap_data[k] : '0, sent_q[k]); end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        stages_in = 3'd0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        test_reset();
        test_min_frame();
        test_max_frame_gaps();
        test_stages_hold();
        test_invalid_codes();
        test_clr();
        test_async_rst();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
